// File: rtl/inst_decode_queue.sv
// Instruction decode queue: a small circular FIFO of fetched {inst, pc} whose head
// entry is split into MIPS fields and presented through a valid/ready handshake.
module inst_decode_queue #(
   parameter int PC_W  = 32,
   parameter int DEPTH = 2,
   parameter int IMM_W = 32
) (
   input  logic                     clk,
   input  logic                     myreset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_inst,
   input  logic [PC_W-1:0]          in_pc,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [5:0]               OP,
   output logic [4:0]               RS,
   output logic [4:0]               RT,
   output logic [4:0]               RD,
   output logic [4:0]               SHMAT,
   output logic [5:0]               FUNC,
   output logic [15:0]              IMME,
   output logic [25:0]              ADDR,
   output logic [IMM_W-1:0]         IMM_SEXT,
   output logic [IMM_W-1:0]         IMM_ZEXT,
   output logic [1:0]               INST_TYPE,
   output logic [PC_W-1:0]          JTARGET,
   output logic [PC_W-1:0]          out_pc,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [31:0]     inst_mem [DEPTH];
   logic [PC_W-1:0] pc_mem   [DEPTH];
   logic [AW-1:0]   wp;
   logic [AW-1:0]   rp;
   logic [CW-1:0]   cnt;
   logic            push;
   logic            pop;
   logic [31:0]     head_inst;
   logic [PC_W-1:0] head_pc;
   logic [PC_W-1:0] jt_raw;

   function automatic logic [IMM_W-1:0] sext16(input logic signed [15:0] v);
      return IMM_W'(v);
   endfunction

   function automatic logic [IMM_W-1:0] zext16(input logic [15:0] v);
      return IMM_W'(v);
   endfunction

   assign in_ready  = (cnt < CW'(DEPTH));
   assign out_valid = (cnt != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign count     = cnt;

   always_ff @(posedge clk) begin
      if (myreset || flush) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push)
            wp <= wp + AW'(1);
         if (pop)
            rp <= rp + AW'(1);
         if (push && !pop)
            cnt <= cnt + CW'(1);
         else if (pop && !push)
            cnt <= cnt - CW'(1);
      end
   end

   // Storage is data only; stale words are hidden by the out_valid gating below.
   always_ff @(posedge clk) begin
      if (push) begin
         inst_mem[wp] <= in_inst;
         pc_mem[wp]   <= in_pc;
      end
   end

   always_comb begin
      head_inst = '0;
      head_pc   = '0;
      if (out_valid) begin
         head_inst = inst_mem[rp];
         head_pc   = pc_mem[rp];
      end
   end

   assign OP       = head_inst[31:26];
   assign RS       = head_inst[25:21];
   assign RT       = head_inst[20:16];
   assign RD       = head_inst[15:11];
   assign SHMAT    = head_inst[10:6];
   assign FUNC     = head_inst[5:0];
   assign IMME     = head_inst[15:0];
   assign ADDR     = head_inst[25:0];
   assign IMM_SEXT = sext16(head_inst[15:0]);
   assign IMM_ZEXT = zext16(head_inst[15:0]);
   assign out_pc   = head_pc;

   always_comb begin
      INST_TYPE = 2'b01;
      if (OP == 6'h00)
         INST_TYPE = 2'b00;
      else if (OP == 6'h02 || OP == 6'h03)
         INST_TYPE = 2'b10;
   end

   // Upper bits of pc+4: adding 4 carries into bit 28 only when pc[27:2] is all ones.
   generate
      if (PC_W == 28) begin : g_jt28
         assign jt_raw = {ADDR, 2'b00};
      end else begin : g_jt
         assign jt_raw = {head_pc[PC_W-1:28] + (PC_W-28)'(&head_pc[27:2]), ADDR, 2'b00};
      end
   endgenerate

   assign JTARGET = out_valid ? jt_raw : '0;

endmodule

// File: tb/tb_inst_decode_queue.sv
// Bench for inst_decode_queue: directed scenarios followed by random traffic, all
// checked against a queue-based reference model of the FIFO and field decoding.
module tb_inst_decode_queue;

   localparam int PC_W  = 32;
   localparam int DEPTH = 2;
   localparam int IMM_W = 32;

   logic        clk = 1'b0;
   logic        myreset;
   logic        in_valid;
   logic [31:0] in_inst;
   logic [31:0] in_pc;
   logic        flush;
   logic        out_ready;
   logic        in_ready;
   logic        out_valid;
   logic [5:0]  OP;
   logic [4:0]  RS;
   logic [4:0]  RT;
   logic [4:0]  RD;
   logic [4:0]  SHMAT;
   logic [5:0]  FUNC;
   logic [15:0] IMME;
   logic [25:0] ADDR;
   logic [31:0] IMM_SEXT;
   logic [31:0] IMM_ZEXT;
   logic [1:0]  INST_TYPE;
   logic [31:0] JTARGET;
   logic [31:0] out_pc;
   logic [1:0]  count;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } ent_t;

   ent_t q[$];
   int   nvec = 0;
   int   nmis = 0;
   logic last_push;

   inst_decode_queue #(.PC_W(PC_W), .DEPTH(DEPTH), .IMM_W(IMM_W)) dut (
      .clk(clk), .myreset(myreset), .in_valid(in_valid), .in_ready(in_ready),
      .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .OP(OP), .RS(RS), .RT(RT), .RD(RD), .SHMAT(SHMAT),
      .FUNC(FUNC), .IMME(IMME), .ADDR(ADDR), .IMM_SEXT(IMM_SEXT), .IMM_ZEXT(IMM_ZEXT),
      .INST_TYPE(INST_TYPE), .JTARGET(JTARGET), .out_pc(out_pc), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nmis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] exp_type(input logic [5:0] op);
      if (op == 6'd0) return 2'b00;
      if (op == 6'd2 || op == 6'd3) return 2'b10;
      return 2'b01;
   endfunction

   // Expected outputs derived from the model's head entry (all zero when empty).
   task automatic check_outputs();
      logic [31:0] i;
      logic [31:0] p;
      logic [31:0] jt;
      logic        ne;
      ne = (q.size() != 0);
      i  = ne ? q[0].inst : 32'd0;
      p  = ne ? q[0].pc   : 32'd0;
      jt = ne ? (((p + 32'd4) & 32'hF000_0000) | ({6'd0, i[25:0]} << 2)) : 32'd0;
      chk("in_ready",  64'(in_ready),  64'(q.size() < DEPTH));
      chk("out_valid", 64'(out_valid), 64'(ne));
      chk("count",     64'(count),     64'(q.size()));
      chk("OP",        64'(OP),        64'(i >> 26));
      chk("RS",        64'(RS),        64'((i >> 21) & 32'h1F));
      chk("RT",        64'(RT),        64'((i >> 16) & 32'h1F));
      chk("RD",        64'(RD),        64'((i >> 11) & 32'h1F));
      chk("SHMAT",     64'(SHMAT),     64'((i >> 6) & 32'h1F));
      chk("FUNC",      64'(FUNC),      64'(i & 32'h3F));
      chk("IMME",      64'(IMME),      64'(i & 32'hFFFF));
      chk("ADDR",      64'(ADDR),      64'(i & 32'h03FF_FFFF));
      chk("IMM_SEXT",  64'(IMM_SEXT),  64'(ne ? {{16{i[15]}}, i[15:0]} : 32'd0));
      chk("IMM_ZEXT",  64'(IMM_ZEXT),  64'(i & 32'hFFFF));
      chk("INST_TYPE", 64'(INST_TYPE), 64'(ne ? exp_type(i[31:26]) : 2'b00));
      chk("JTARGET",   64'(JTARGET),   64'(jt));
      chk("out_pc",    64'(out_pc),    64'(p));
   endtask

   // One clock: check mid-cycle, then advance the model with the edge's inputs.
   task automatic step();
      ent_t e;
      logic pu;
      logic po;
      #4;
      check_outputs();
      @(posedge clk);
      last_push = 1'b0;
      if (myreset || flush) begin
         q.delete();
      end else begin
         pu = in_valid && (q.size() < DEPTH);
         po = (q.size() != 0) && out_ready;
         if (po) void'(q.pop_front());
         if (pu) begin
            e.inst = in_inst;
            e.pc   = in_pc;
            q.push_back(e);
         end
         last_push = pu;
      end
      #1;
   endtask

   task automatic drive(input logic [31:0] inst, input logic [31:0] pc);
      in_valid = 1'b1;
      in_inst  = inst;
      in_pc    = pc;
   endtask

   initial begin
      logic [31:0] r;
      logic [5:0]  op;
      myreset   = 1'b1;
      flush     = 1'b0;
      out_ready = 1'b0;
      drive(32'h2108_FFFC, 32'h0040_0000);
      last_push = 1'b0;

      // reset held for two edges with a push offered
      @(posedge clk);
      @(posedge clk);
      #1;
      q.delete();
      myreset  = 1'b0;
      in_valid = 1'b0;
      chk("rst_in_ready",  64'(in_ready),  64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_count",     64'(count),     64'd0);
      chk("rst_out_pc",    64'(out_pc),    64'd0);
      step();

      // single R-type
      drive(32'h012A_4020, 32'h0040_0000);
      step();
      in_valid = 1'b0;
      chk("r_OP",   64'(OP),        64'd0);
      chk("r_RS",   64'(RS),        64'd9);
      chk("r_RT",   64'(RT),        64'd10);
      chk("r_RD",   64'(RD),        64'd8);
      chk("r_FUNC", 64'(FUNC),      64'h20);
      chk("r_TYPE", 64'(INST_TYPE), 64'd0);
      chk("r_cnt",  64'(count),     64'd1);
      step();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // I-type sign extension
      drive(32'h2108_FFFC, 32'h0040_0004);
      step();
      in_valid = 1'b0;
      chk("i_SEXT", 64'(IMM_SEXT),  64'hFFFF_FFFC);
      chk("i_ZEXT", 64'(IMM_ZEXT),  64'h0000_FFFC);
      chk("i_TYPE", 64'(INST_TYPE), 64'd1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // J-type target
      drive(32'h0C10_0008, 32'h0040_0010);
      step();
      in_valid = 1'b0;
      chk("j_ADDR", 64'(ADDR),      64'h010_0008);
      chk("j_JT",   64'(JTARGET),   64'h0040_0020);
      chk("j_TYPE", 64'(INST_TYPE), 64'd2);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // full queue with back-pressure; third word held by the source
      drive(32'h0000_0001, 32'h0000_1000);
      step();
      drive(32'h2000_0002, 32'h0000_1004);
      step();
      drive(32'h0800_0003, 32'h0000_1008);
      step();
      chk("full_in_ready", 64'(in_ready), 64'd0);
      chk("full_count",    64'(count),    64'd2);
      chk("full_held",     64'(last_push), 64'd0);
      out_ready = 1'b1;
      step();
      chk("pop1_in_ready", 64'(in_ready), 64'd1);
      chk("pop1_head_pc",  64'(out_pc),   64'h1004);
      step();
      in_valid = 1'b0;
      chk("pop2_head_pc",  64'(out_pc),   64'h1008);
      step();
      out_ready = 1'b0;

      // flush with a simultaneous push at count 2
      drive(32'h0000_0011, 32'h0000_2000);
      step();
      drive(32'h0000_0012, 32'h0000_2004);
      step();
      drive(32'hDEAD_BEEF, 32'h0000_2008);
      flush = 1'b1;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_count", 64'(count),     64'd0);
      chk("flush_valid", 64'(out_valid), 64'd0);
      out_ready = 1'b1;
      step();

      // random traffic, including rare flush and mid-stream reset
      for (int n = 0; n < 400; n++) begin
         r = $urandom;
         case ($urandom_range(0, 3))
            0:       op = 6'h00;
            1:       op = 6'h02;
            2:       op = 6'h03;
            default: op = r[31:26];
         endcase
         in_inst = {op, r[25:0]};
         r = $urandom;
         r[1:0] = 2'b00;
         if ($urandom_range(0, 3) == 0) r[27:2] = '1;
         in_pc     = r;
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 31) == 0);
         myreset   = ($urandom_range(0, 63) == 0);
         step();
      end
      myreset  = 1'b0;
      flush    = 1'b0;
      in_valid = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
